// File: rtl/levenshtein_pattern_loader.sv
// Builds the per-character match-bitvector table for the Levenshtein controller in external SRAM.
// A search word is streamed in, stale entries are zeroed, and each distinct character's position mask is written over Wishbone.
module levenshtein_pattern_loader #(
   parameter int unsigned MASTER_ADDR_WIDTH = 24,
   parameter int unsigned BITVECTOR_WIDTH   = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 chr_valid_i,
   output logic                                 chr_ready_o,
   input  logic [7:0]                           chr_data_i,
   input  logic                                 chr_last_i,
   output logic                                 wbm_cyc_o,
   output logic                                 wbm_stb_o,
   output logic [MASTER_ADDR_WIDTH-1:0]         wbm_adr_o,
   output logic                                 wbm_we_o,
   output logic [7:0]                           wbm_dat_o,
   output logic [2:0]                           wbm_cti_o,
   output logic [1:0]                           wbm_bte_o,
   input  logic                                 wbm_ack_i,
   input  logic                                 wbm_err_i,
   input  logic                                 wbm_rty_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 error_o,
   output logic [$clog2(BITVECTOR_WIDTH)-1:0]   word_len_m1_o
);
   localparam int unsigned W        = BITVECTOR_WIDTH;
   localparam int unsigned BYTES    = (W + 7) / 8;
   localparam int unsigned SUFFIX_W = $clog2(BYTES);
   localparam int unsigned SFX_W    = (SUFFIX_W == 0) ? 1 : SUFFIX_W;
   localparam int unsigned PAD_W    = BYTES * 8;
   localparam int unsigned PI_W     = $clog2(W);
   localparam int unsigned LM1_W    = $clog2(W);
   localparam int unsigned LEN_W    = $clog2(W + 1);
   localparam int unsigned IDX_W    = (LEN_W > 9) ? LEN_W : 9;

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_CLR_ALL, S_CLR_PREV, S_WRITE, S_DONE
   } state_e;

   state_e                   state_q;
   logic [7:0]               new_q  [W];
   logic [7:0]               prev_q [W];
   logic [LEN_W-1:0]         cnt_q, len_q, prevcnt_q;
   logic [IDX_W-1:0]         idx_q;
   logic [SFX_W-1:0]         beat_q;
   logic [7:0]               chr_q;
   logic [PAD_W-1:0]         vec_q;
   logic                     dirty_q, err_q, done_q, cyc_q;
   logic [MASTER_ADDR_WIDTH-1:0] adr_q;
   logic [7:0]               dat_q;
   logic [2:0]               cti_q;
   logic [LM1_W-1:0]         wlen_q;

   logic [PI_W-1:0]          pos;
   logic                     dup_prev_d, dup_new_d;
   logic [W-1:0]             vec_new_d;
   logic [7:0]               item_chr_d;
   logic [PAD_W-1:0]         item_vec_d;
   logic                     item_skip_d, item_end_d;

   function automatic logic [MASTER_ADDR_WIDTH-1:0] beat_adr(input logic [7:0] ch,
                                                             input logic [SFX_W-1:0] sfx);
      beat_adr = (MASTER_ADDR_WIDTH'(1) << (8 + SUFFIX_W))
               | (MASTER_ADDR_WIDTH'(ch) << SUFFIX_W)
               | MASTER_ADDR_WIDTH'(sfx);
   endfunction

   // Suffix 0 carries the most significant byte of the zero-padded vector.
   function automatic logic [7:0] beat_dat(input logic [PAD_W-1:0] vec,
                                           input logic [SFX_W-1:0] sfx);
      beat_dat = 8'(vec >> ((BYTES - 1 - 32'(sfx)) * 8));
   endfunction

   function automatic logic [2:0] beat_cti(input logic [SFX_W-1:0] sfx);
      if (BYTES == 1)                beat_cti = 3'b000;
      else if (32'(sfx) == BYTES - 1) beat_cti = 3'b111;
      else                           beat_cti = 3'b010;
   endfunction

   assign pos = idx_q[PI_W-1:0];

   always_comb begin
      dup_prev_d = 1'b0;
      dup_new_d  = 1'b0;
      vec_new_d  = '0;
      for (int unsigned j = 0; j < W; j++) begin
         if (j < 32'(pos)) begin
            if (prev_q[PI_W'(j)] == prev_q[pos]) dup_prev_d = 1'b1;
            if (new_q[PI_W'(j)] == new_q[pos])   dup_new_d  = 1'b1;
         end
         if (j < 32'(len_q) && new_q[PI_W'(j)] == new_q[pos]) vec_new_d[j] = 1'b1;
      end
   end

   // Next table entry to write for the current phase, or end-of-phase / skip-duplicate.
   always_comb begin
      item_chr_d  = '0;
      item_vec_d  = '0;
      item_skip_d = 1'b0;
      item_end_d  = 1'b0;
      case (state_q)
         S_CLR_ALL: begin
            item_chr_d = idx_q[7:0];
            item_end_d = (idx_q == IDX_W'(256));
         end
         S_CLR_PREV: begin
            item_chr_d  = prev_q[pos];
            item_end_d  = (idx_q == IDX_W'(prevcnt_q));
            item_skip_d = dup_prev_d;
         end
         S_WRITE: begin
            item_chr_d  = new_q[pos];
            item_vec_d  = PAD_W'(vec_new_d);
            item_end_d  = (idx_q == IDX_W'(len_q));
            item_skip_d = dup_new_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         for (int unsigned i = 0; i < W; i++) begin
            new_q[i]  <= '0;
            prev_q[i] <= '0;
         end
         cnt_q     <= '0;
         len_q     <= '0;
         prevcnt_q <= '0;
         idx_q     <= '0;
         beat_q    <= '0;
         chr_q     <= '0;
         vec_q     <= '0;
         dirty_q   <= 1'b1;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         cyc_q     <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         cti_q     <= '0;
         wlen_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_COLLECT: begin
               if (chr_valid_i) begin
                  if (cnt_q == '0) err_q <= 1'b0;
                  if (cnt_q < LEN_W'(W)) begin
                     new_q[cnt_q[PI_W-1:0]] <= chr_data_i;
                     cnt_q <= cnt_q + LEN_W'(1);
                  end else begin
                     err_q <= 1'b1;
                  end
                  if (chr_last_i) begin
                     len_q   <= (cnt_q < LEN_W'(W)) ? cnt_q + LEN_W'(1) : cnt_q;
                     cnt_q   <= '0;
                     idx_q   <= '0;
                     state_q <= dirty_q ? S_CLR_ALL : S_CLR_PREV;
                  end else begin
                     state_q <= S_COLLECT;
                  end
               end
            end
            S_CLR_ALL, S_CLR_PREV, S_WRITE: begin
               if (cyc_q) begin
                  if (wbm_err_i || wbm_rty_i) begin
                     cyc_q   <= 1'b0;
                     err_q   <= 1'b1;
                     dirty_q <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (wbm_ack_i) begin
                     if (32'(beat_q) == BYTES - 1) begin
                        cyc_q <= 1'b0;
                        idx_q <= idx_q + IDX_W'(1);
                     end else begin
                        beat_q <= beat_q + SFX_W'(1);
                        adr_q  <= beat_adr(chr_q, beat_q + SFX_W'(1));
                        dat_q  <= beat_dat(vec_q, beat_q + SFX_W'(1));
                        cti_q  <= beat_cti(beat_q + SFX_W'(1));
                     end
                  end
               end else if (item_end_d) begin
                  idx_q <= '0;
                  if (state_q == S_CLR_ALL) begin
                     dirty_q <= 1'b0;
                     state_q <= S_WRITE;
                  end else if (state_q == S_CLR_PREV) begin
                     state_q <= S_WRITE;
                  end else begin
                     state_q <= S_DONE;
                  end
               end else if (item_skip_d) begin
                  idx_q <= idx_q + IDX_W'(1);
               end else begin
                  cyc_q  <= 1'b1;
                  beat_q <= '0;
                  chr_q  <= item_chr_d;
                  vec_q  <= item_vec_d;
                  adr_q  <= beat_adr(item_chr_d, '0);
                  dat_q  <= beat_dat(item_vec_d, '0);
                  cti_q  <= beat_cti('0);
               end
            end
            S_DONE: begin
               prev_q    <= new_q;
               prevcnt_q <= len_q;
               wlen_q    <= LM1_W'(len_q - LEN_W'(1));
               done_q    <= 1'b1;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign chr_ready_o   = (state_q == S_IDLE) || (state_q == S_COLLECT);
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign error_o       = err_q;
   assign word_len_m1_o = wlen_q;
   assign wbm_cyc_o     = cyc_q;
   assign wbm_stb_o     = cyc_q;
   assign wbm_adr_o     = adr_q;
   assign wbm_we_o      = 1'b1;
   assign wbm_dat_o     = dat_q;
   assign wbm_cti_o     = cti_q;
   assign wbm_bte_o     = 2'b00;

endmodule
